// File: rtl/fetch_queue.sv
// Elastic IF->ID instruction queue: DEPTH-entry circular buffer with a valid/ready
// fetch side and STALL/FLUSH semantics on the decode side.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FLUSH,
  input  logic               STALL,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [INSTR_W-1:0] Instr1_IF,
  input  logic [ADDR_W-1:0]  Instr_PC_IF,
  input  logic [ADDR_W-1:0]  Instr_PC_Plus4_IF,
  output logic               OUT_VALID,
  output logic [INSTR_W-1:0] Instr1_OUT,
  output logic [ADDR_W-1:0]  Instr_PC_OUT,
  output logic [ADDR_W-1:0]  Instr_PC_Plus4,
  output logic [CW-1:0]      COUNT,
  output logic               FULL,
  output logic               EMPTY
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  // Status flags come only from registered occupancy, never from the handshake inputs.
  assign FULL      = (count == CW'(DEPTH));
  assign EMPTY     = (count == '0);
  assign IN_READY  = !FULL;
  assign OUT_VALID = !EMPTY;
  assign COUNT     = count;

  assign push = IN_VALID && IN_READY && !FLUSH;
  assign pop  = OUT_VALID && !STALL && !FLUSH;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; empty gating hides stale contents.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{instr: Instr1_IF, pc: Instr_PC_IF, pc_plus4: Instr_PC_Plus4_IF};
  end

  assign head           = mem[rd_ptr];
  assign Instr1_OUT     = EMPTY ? '0 : head.instr;
  assign Instr_PC_OUT   = EMPTY ? '0 : head.pc;
  assign Instr_PC_Plus4 = EMPTY ? '0 : head.pc_plus4;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed + random bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        CLK = 0, RESET = 0, FLUSH = 0, STALL = 0, IN_VALID = 0;
  logic [31:0] Instr1_IF = 0, Instr_PC_IF = 0, Instr_PC_Plus4_IF = 0;
  logic        IN_READY, OUT_VALID, FULL, EMPTY;
  logic [31:0] Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4;
  logic [2:0]  COUNT;

  fetch_queue #(.DEPTH(DEPTH), .INSTR_W(32), .ADDR_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .Instr1_IF(Instr1_IF), .Instr_PC_IF(Instr_PC_IF), .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF),
    .OUT_VALID(OUT_VALID), .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT),
    .Instr_PC_Plus4(Instr_PC_Plus4), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] i, p, p4; } ent_t;
  ent_t q[$];
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count"}, 32'(COUNT), 32'(n));
    chk({tag, ":full"}, 32'(FULL), 32'(n == DEPTH));
    chk({tag, ":empty"}, 32'(EMPTY), 32'(n == 0));
    chk({tag, ":in_ready"}, 32'(IN_READY), 32'(n != DEPTH));
    chk({tag, ":out_valid"}, 32'(OUT_VALID), 32'(n != 0));
    chk({tag, ":instr"}, Instr1_OUT, n ? q[0].i : 32'h0);
    chk({tag, ":pc"}, Instr_PC_OUT, n ? q[0].p : 32'h0);
    chk({tag, ":pc4"}, Instr_PC_Plus4, n ? q[0].p4 : 32'h0);
  endtask

  // Called at a negedge: drive, check, clock, update model, return at next negedge.
  task automatic cycle(input string tag, input logic v, input logic s, input logic f,
                       input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4);
    bit do_push, do_pop;
    ent_t e;
    IN_VALID = v; STALL = s; FLUSH = f;
    Instr1_IF = ins; Instr_PC_IF = pc; Instr_PC_Plus4_IF = pc4;
    check_all(tag);
    @(posedge CLK);
    do_push = v && (q.size() < DEPTH) && !f;
    do_pop  = (q.size() > 0) && !s && !f;
    if (!RESET || f) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin e.i = ins; e.p = pc; e.p4 = pc4; q.push_back(e); end
    end
    @(negedge CLK);
  endtask

  task automatic push_pc(input string tag, input logic s, input logic [31:0] ins, input logic [31:0] pc);
    cycle(tag, 1'b1, s, 1'b0, ins, pc, pc + 32'd4);
  endtask

  task automatic idle(input string tag, input logic s);
    cycle(tag, 1'b0, s, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset then idle
    @(negedge CLK);
    check_all("in_reset");
    RESET = 1;
    for (int k = 0; k < 5; k++) idle("idle", 1'b0);

    // Fill under stall; 0x110 must bounce off a full queue
    for (int k = 0; k < 4; k++) push_pc("fill", 1'b1, 32'hA0 + k, 32'h100 + 4 * k);
    for (int k = 0; k < 2; k++) begin
      chk("fill_full", 32'(FULL), 32'd1);
      chk("fill_head_pc", Instr_PC_OUT, 32'h100);
      push_pc("full_hold", 1'b1, 32'hA4, 32'h110);
    end
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", Instr_PC_OUT, 32'h100 + 4 * k);
      idle("drain", 1'b0);
    end
    chk("drain_empty", 32'(EMPTY), 32'd1);

    // Streaming across the pointer wrap
    for (int k = 0; k < 10; k++) begin
      push_pc("stream", 1'b0, 32'hB0 + k, 32'h200 + 4 * k);
      chk("stream_lat", Instr_PC_OUT, 32'h200 + 4 * k);
      chk("stream_cnt_le1", 32'(COUNT <= 1), 32'd1);
    end
    idle("stream_tail", 1'b0);

    // Simultaneous push and pop at COUNT = 2
    push_pc("pp_a", 1'b1, 32'hC0, 32'h500);
    push_pc("pp_b", 1'b1, 32'hC1, 32'h504);
    push_pc("pp_both", 1'b0, 32'hC2, 32'h508);
    chk("pp_count", 32'(COUNT), 32'd2);
    chk("pp_head", Instr_PC_OUT, 32'h504);
    idle("pp_drain", 1'b0);
    chk("pp_tail", Instr_PC_OUT, 32'h508);
    idle("pp_drain", 1'b0);

    // FLUSH with a concurrent push that must be dropped
    for (int k = 0; k < 3; k++) push_pc("fl_fill", 1'b1, 32'hD0 + k, 32'h600 + 4 * k);
    cycle("flush", 1'b1, 1'b1, 1'b1, 32'hDD, 32'h300, 32'h304);
    chk("flush_count", 32'(COUNT), 32'd0);
    chk("flush_pc", Instr_PC_OUT, 32'h0);
    push_pc("post_flush", 1'b0, 32'hDE, 32'h304);
    chk("post_flush_head", Instr_PC_OUT, 32'h304);
    idle("pf_drain", 1'b0);

    // Asynchronous reset between edges
    push_pc("ar_a", 1'b1, 32'hE0, 32'h700);
    push_pc("ar_b", 1'b1, 32'hE1, 32'h704);
    chk("ar_pre_count", 32'(COUNT), 32'd2);
    #2 RESET = 0;
    #1;
    q.delete();
    chk("ar_count_now", 32'(COUNT), 32'd0);
    check_all("ar_now");
    @(negedge CLK);
    RESET = 1;
    push_pc("ar_post", 1'b0, 32'hE2, 32'h400);
    chk("ar_post_head", Instr_PC_OUT, 32'h400);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      cycle("rand", 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 39) == 0), $urandom, $urandom, $urandom);
    end
    for (int k = 0; k < DEPTH + 1; k++) idle("final_drain", 1'b0);
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised elastic instruction queue between the IF and ID stages. It replaces the single-entry IF/ID pipeline register with a DEPTH-entry circular buffer and a valid/ready handshake on the fetch side. The ID side keeps the existing STALL and FLUSH semantics. Fetch can run ahead of a stalled decode by up to DEPTH instructions.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2.
- INSTR_W, 32, instruction width.
- ADDR_W, 32, PC width.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset. Clock is CLK.
- FLUSH  in  1  synchronous; discards every entry, including any push in the same cycle.
- STALL  in  1  ID not accepting; the head entry is held.
- IN_VALID  in  1  IF presents an instruction.
- IN_READY  out  1  queue can accept; equals !FULL.
- Instr1_IF  in  INSTR_W  fetched instruction.
- Instr_PC_IF  in  ADDR_W  address of the fetched instruction.
- Instr_PC_Plus4_IF  in  ADDR_W  next sequential address.
- OUT_VALID  out  1  head entry is valid; equals !EMPTY.
- Instr1_OUT  out  INSTR_W  head instruction; 0 when empty.
- Instr_PC_OUT  out  ADDR_W  head PC; 0 when empty.
- Instr_PC_Plus4  out  ADDR_W  head next-PC; 0 when empty.
- COUNT  out  $clog2(DEPTH+1)  occupied entries, 0..DEPTH.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.

## Operation
- Storage: DEPTH entries, each holding {instr, pc, pc_plus4}.
- Pointers: wr_ptr and rd_ptr, $clog2(DEPTH) bits each, wrapping modulo DEPTH by natural overflow. A separate occupancy counter distinguishes full from empty.
- push = IN_VALID && IN_READY && !FLUSH.
  - Writes the entry at wr_ptr.
  - wr_ptr increments by 1.
- pop = OUT_VALID && !STALL && !FLUSH.
  - rd_ptr increments by 1.
  - The entry is consumed by ID in the same cycle it is presented.
- COUNT update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. Both pointers advance.
- Full: IN_READY = 0, so no push occurs, even if a pop happens in the same cycle. There is no full-pass-through.
- Empty: OUT_VALID = 0, so no pop occurs. A push while empty becomes visible on the outputs in the next cycle; there is no combinational bypass.
- Outputs: combinational read of the entry at rd_ptr, gated to 0 when EMPTY. A bubble therefore presents all zeros, which is a NOP to ID.
- FLUSH has priority over STALL, push and pop.
  - Clears wr_ptr, rd_ptr and COUNT.
  - Stored data need not be cleared; the empty gating zeroes the outputs.
- RESET (asynchronous, active-low):
  - Pointers and COUNT go to 0.
  - All outputs go to 0, except IN_READY = 1 and EMPTY = 1.
  - Takes effect immediately, mid-operation included. All entries are lost.
- Simulation-only $display lines for push, pop, stall-hold, FLUSH and RESET are permitted. They must not affect behaviour.

## Timing
- Latency from push to the entry at the outputs:
  - 1 cycle when the queue is empty.
  - Otherwise, after all older entries have popped.
- Throughput: one push and one pop per cycle sustained, whenever 0 < COUNT < DEPTH.
- IN_READY, FULL, EMPTY, OUT_VALID and COUNT are registered-state functions. None depends combinationally on IN_VALID, STALL or FLUSH.
- STALL asserted: the outputs are stable cycle to cycle. They change only on a push into an empty queue, FLUSH, or RESET.
- Wrap-around: after DEPTH pushes, wr_ptr returns to 0 with no gap in ordering. Entries pop strictly FIFO.
- FLUSH at cycle N: in cycle N+1, COUNT = 0, OUT_VALID = 0, outputs = 0, IN_READY = 1.

## Test plan
- Reset then idle:
  - Stimulus: RESET low; then IN_VALID = 0 for 5 cycles.
  - Required: outputs 0, COUNT = 0, EMPTY = 1, IN_READY = 1 throughout.
- Fill under stall and drain (DEPTH = 4):
  - Stimulus: STALL = 1; push PCs 0x100, 0x104, 0x108, 0x10C (instr 0xA0..0xA3, Plus4 = PC+4); then hold IN_VALID = 1 with PC 0x110 for 2 more cycles.
  - Required: FULL = 1; IN_READY = 0; 0x110 is not accepted; the outputs hold PC 0x100 / 0xA0 / 0x104 for all stall cycles.
  - Then release STALL: PCs 0x100..0x10C emerge one per cycle, in order, then EMPTY = 1.
- Streaming with wrap:
  - Stimulus: STALL = 0; push 10 consecutive PCs from 0x200 in step 4.
  - Required: each appears on the outputs exactly 1 cycle after its push; COUNT stays at most 1; order is preserved across the pointer wrap.
- Simultaneous push and pop at COUNT = 2:
  - Required: COUNT remains 2; the head advances to the next entry; the new entry lands at the tail.
- FLUSH:
  - Stimulus: with COUNT = 3 and STALL = 1, assert FLUSH while IN_VALID = 1 (PC 0x300).
  - Required: next cycle COUNT = 0, outputs 0, and 0x300 is dropped.
  - A subsequent push of 0x304 is the next output.
- Asynchronous reset mid-stream:
  - Stimulus: with COUNT = 2, pull RESET low between clock edges.
  - Required: outputs and COUNT are 0 immediately, before the next edge; after release, a push of 0x400 appears 1 cycle later.
